// File: rtl/encoder_8x3_stream_if.sv
// Handshake bundle for encoder_8x3_stream: an 8-bit request stream in,
// a stream of 3-bit indices out. The encoder takes the slave view;
// whatever feeds requests and consumes codes takes the master view.
interface encoder_8x3_stream_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_last;
  logic       out_none;
  logic [3:0] out_count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_last, out_none, out_count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_last, out_none, out_count
  );
endinterface

// File: rtl/encoder_8x3_stream.sv
// Sequential 8-to-3 encoder. Accepts a request vector and then emits the
// binary index of every set bit, lowest first, one per output handshake.
// Every output is a register; next values are computed from the next
// pending vector so that a new code appears the cycle after a handshake.
module encoder_8x3_stream (
  input  logic                          clk,
  input  logic                          rst,
  encoder_8x3_stream_if.slave           bus
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [3:0] count_q, count_d;
  logic [2:0] code_q, code_d;
  logic       last_q, last_d;
  logic       none_q, none_d;
  logic       valid_q, valid_d;
  logic       ready_q, ready_d;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  // Scanning downward leaves the lowest set index as the final winner.
  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  // State, pending vector and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 8'd0;
      count_q   <= 4'd0;
      code_q    <= 3'd0;
      last_q    <= 1'b0;
      none_q    <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      code_q    <= code_d;
      last_q    <= last_d;
      none_q    <= none_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  // Next state: load on input handshake, drain one bit per output handshake.
  // NOTE: every signal gets a hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && ready_q) begin
          pending_d = bus.in_data;
          count_d   = popcount8(bus.in_data);
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (bus.out_ready) begin
          // v & (v-1) clears the lowest set bit, i.e. the one just emitted.
          pending_d = pending_q & (pending_q - 8'd1);
          if (last_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values derived from where the FSM and pending vector go next.
  always_comb begin
    valid_d = (state_d == BUSY);
    ready_d = (state_d == IDLE);
    code_d  = 3'd0;
    last_d  = 1'b0;
    none_d  = 1'b0;
    if (state_d == BUSY) begin
      code_d = lowest_index(pending_d);
      // At most one bit left: true for the final set bit and the zero vector.
      last_d = ((pending_d & (pending_d - 8'd1)) == 8'd0);
      none_d = (pending_d == 8'd0);
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_code  = code_q;
  assign bus.out_last  = last_q;
  assign bus.out_none  = none_q;
  assign bus.out_count = count_q;

endmodule
